// File: rtl/spi_arb_pkg.sv
// -----------------------------------------------------------------------------
// spi_arb_pkg
// Shared types and helpers for the SPI request arbiter:
//   state_t  - arbiter/serialiser FSM states
//   idx_w    - index width helper (never less than 1 bit)
//   rr_pick  - round-robin search: first set request after ptr, wrapping at n
// No ports (package).
// -----------------------------------------------------------------------------
package spi_arb_pkg;

    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ACT   = 3'd2,
        ST_CLK0  = 3'd3,
        ST_CLK1  = 3'd4,
        ST_DEACT = 3'd5,
        ST_GAP   = 3'd6
    } state_t;

    // Width of an index into n items; a single item still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Searches ptr+1, ptr+2, ... (mod n) and returns the first set request.
    // Returns ptr when nothing is set; the caller qualifies with |req.
    function automatic logic [MAX_ID_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  req,
        input logic [MAX_ID_W-1:0] ptr,
        input int                  n
    );
        logic [MAX_ID_W-1:0] pick;
        logic                found;
        logic [3:0]          j;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            j = {1'b0, ptr} + 4'(k);
            if (j >= 4'(n)) j = j - 4'(n);
            if (!found && (k <= n) && req[j[2:0]]) begin
                pick  = j[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// -----------------------------------------------------------------------------
// spi_tick_gen
// Free-running divider producing the SPI half-bit tick: the counter runs
// 0..CLK_DIV/2-1 and o_tick is high while it sits at its terminal count.
// Ports:
//   i_clk      in  system clock
//   i_reset_n  in  synchronous reset, active low (counter -> 0)
//   o_tick     out one-clk strobe every CLK_DIV/2 clocks
// -----------------------------------------------------------------------------
module spi_tick_gen
    import spi_arb_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    output logic o_tick
);

    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = idx_w(HALF);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(HALF - 1));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// -----------------------------------------------------------------------------
// spi_req_arbiter
// Shares one write-only SPI port among N_REQ requesters with round-robin
// grant. Each grant becomes one frame: ncs low, N_BITS bits MSB-first
// (mosi changes with the falling spi_clk, slave samples on the rise),
// ncs high, ack pulse, then GAP idle ticks before the next arbitration.
//
// Handshake: req[i] is a level; the requester holds it (and its req_data
// slice) until ack[i] pulses for one clk. req_data is captured at grant, so
// later changes never reach the frame in flight. A req dropped before the
// arbitration tick is simply not served.
//
// Ports:
//   clk, reset_n  system clock, synchronous active-low reset
//   req           level requests, one per requester
//   req_data      frame data, slice i = req_data[i*N_BITS +: N_BITS]
//   ack           one-clk completion pulse on the served index
//   busy          high from grant through the ack cycle
//   grant_id      index of the current / last granted requester
//   spi_clk       SPI clock, idles high
//   spi_ncs       chip select, active low
//   spi_mosi      serial data out, idles high
// Optional (macro SPI_REQ_ARBITER_READBACK_EN):
//   spi_miso      serial data in, sampled on each rising spi_clk
//   rd_data       captured word, updated at frame end
//   rd_valid      one-clk pulse coincident with ack
// -----------------------------------------------------------------------------
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int N_BITS  = 16,
    parameter int CLK_DIV = 4,
    parameter int GAP     = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*N_BITS-1:0]   req_data,
`ifdef SPI_REQ_ARBITER_READBACK_EN
    input  logic                      spi_miso,
    output logic [N_BITS-1:0]         rd_data,
    output logic                      rd_valid,
`endif
    output logic [N_REQ-1:0]          ack,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      spi_clk,
    output logic                      spi_ncs,
    output logic                      spi_mosi
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int BIT_W = idx_w(N_BITS);

    logic              w_tick;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   w_pick;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_grant_id;
    logic [N_BITS-1:0] r_shift;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [3:0]        r_gap;
    logic [N_REQ-1:0]  r_ack;
    logic              r_busy;
    logic              r_spi_clk;
    logic              r_spi_ncs;
    logic              r_spi_mosi;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .o_tick    (w_tick)
    );

    assign w_pick = ID_W'(rr_pick(MAX_REQ'(req), MAX_ID_W'(r_rr_ptr), N_REQ));

    // State register: the FSM moves only on the divider tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else if (w_tick) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (|req) w_state_nxt = ST_ARB;
            ST_ARB:   w_state_nxt = (|req) ? ST_ACT : ST_IDLE;
            ST_ACT:   w_state_nxt = ST_CLK0;
            ST_CLK0:  w_state_nxt = ST_CLK1;
            ST_CLK1:  w_state_nxt = (r_bit_cnt == '0) ? ST_DEACT : ST_CLK0;
            ST_DEACT: w_state_nxt = ST_GAP;
            ST_GAP:   if (r_gap == '0) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and SPI line registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rr_ptr   <= ID_W'(N_REQ - 1);
            r_grant_id <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_gap      <= '0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_spi_clk  <= 1'b1;
            r_spi_ncs  <= 1'b1;
            r_spi_mosi <= 1'b1;
        end else begin
            r_ack <= '0;
            // busy falls the clk after ack so it covers the ack cycle.
            if (r_ack != '0) r_busy <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_IDLE: ;
                    ST_ARB: begin
                        if (|req) begin
                            r_shift    <= req_data[w_pick*N_BITS +: N_BITS];
                            r_grant_id <= w_pick;
                            r_rr_ptr   <= w_pick;
                            r_busy     <= 1'b1;
                        end
                    end
                    ST_ACT: begin
                        r_spi_ncs <= 1'b0;
                        r_bit_cnt <= BIT_W'(N_BITS - 1);
                    end
                    ST_CLK0: begin
                        r_spi_clk  <= 1'b0;
                        r_spi_mosi <= r_shift[r_bit_cnt];
                    end
                    ST_CLK1: begin
                        r_spi_clk <= 1'b1;
                        if (r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - BIT_W'(1);
                    end
                    ST_DEACT: begin
                        r_spi_ncs  <= 1'b1;
                        r_spi_mosi <= 1'b1;
                        r_ack      <= N_REQ'(1) << r_grant_id;
                        r_gap      <= 4'(GAP - 1);
                    end
                    ST_GAP: begin
                        if (r_gap != '0) r_gap <= r_gap - 4'd1;
                    end
                    default: begin
                        // Unreachable encoding: release the bus while the
                        // state register returns to IDLE.
                        r_spi_ncs  <= 1'b1;
                        r_spi_clk  <= 1'b1;
                        r_spi_mosi <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef SPI_REQ_ARBITER_READBACK_EN
    logic [N_BITS-1:0] r_rd_shift;
    logic [N_BITS-1:0] r_rd_data;
    logic              r_rd_valid;

    // miso is captured at the same tick that raises spi_clk, using the
    // bit counter so the first sampled bit lands in the MSB.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_shift <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (w_tick && (r_state == ST_CLK1)) begin
                r_rd_shift[r_bit_cnt] <= spi_miso;
            end
            if (w_tick && (r_state == ST_DEACT)) begin
                r_rd_data  <= r_rd_shift;
                r_rd_valid <= 1'b1;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

    assign ack      = r_ack;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;
    assign spi_clk  = r_spi_clk;
    assign spi_ncs  = r_spi_ncs;
    assign spi_mosi = r_spi_mosi;

endmodule

// File: tb/tb_spi_req_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_req_arbiter
// Directed bench for spi_req_arbiter (N_REQ=4, N_BITS=16, CLK_DIV=4, GAP=2).
// A line monitor decodes ncs windows, rising spi_clk edges and mosi bits;
// the directed sequence compares them against hand-computed frames.
// Build with SPI_REQ_ARBITER_READBACK_EN defined to include the miso model.
// -----------------------------------------------------------------------------
module tb_spi_req_arbiter;
    import spi_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  grant_id;
    logic        spi_clk;
    logic        spi_ncs;
    logic        spi_mosi;
`ifdef SPI_REQ_ARBITER_READBACK_EN
    logic        spi_miso = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [15:0] rb_pat = 16'h1234;
    int          rb_idx = 15;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // line monitor state
    int          nrise   = 0;
    int          nframes = 0;
    int          n_acks  = 0;
    logic [15:0] cap     = '0;
    longint      t_rise  = 0;
    longint      t_fall  = 0;
    int          lo_clks = 0;
    int          hi_clks = 0;
    logic        prev_clk = 1'bx;
    logic        prev_ncs = 1'bx;

    spi_req_arbiter #(
        .N_REQ   (4),
        .N_BITS  (16),
        .CLK_DIV (4),
        .GAP     (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_data (req_data),
`ifdef SPI_REQ_ARBITER_READBACK_EN
        .spi_miso (spi_miso),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
`endif
        .ack      (ack),
        .busy     (busy),
        .grant_id (grant_id),
        .spi_clk  (spi_clk),
        .spi_ncs  (spi_ncs),
        .spi_mosi (spi_mosi)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // SPI line decoder (and miso model when readback is built in)
    always @(spi_clk or spi_ncs) begin
        if (prev_ncs === 1'b1 && spi_ncs === 1'b0) begin
            nframes = nframes + 1;
            cap     = '0;
            nrise   = 0;
            t_fall  = $time;
            if (t_rise != 0) hi_clks = int'((t_fall - t_rise) / 10);
`ifdef SPI_REQ_ARBITER_READBACK_EN
            rb_idx = 15;
`endif
        end
        if (prev_ncs === 1'b0 && spi_ncs === 1'b1) begin
            t_rise  = $time;
            lo_clks = int'((t_rise - t_fall) / 10);
        end
        if (prev_clk === 1'b0 && spi_clk === 1'b1 && spi_ncs === 1'b0) begin
            cap   = {cap[14:0], spi_mosi};
            nrise = nrise + 1;
        end
`ifdef SPI_REQ_ARBITER_READBACK_EN
        if (prev_clk === 1'b1 && spi_clk === 1'b0 && spi_ncs === 1'b0) begin
            spi_miso = rb_pat[rb_idx];
            if (rb_idx > 0) rb_idx = rb_idx - 1;
        end
`endif
        prev_clk = spi_clk;
        prev_ncs = spi_ncs;
    end

    always @(negedge clk) begin
        if (ack != 4'b0000) n_acks = n_acks + 1;
    end

    // driver / check tasks
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Returns at the negedge where ack is seen; a = 0 on budget expiry.
    task automatic wait_ack(input int budget, output logic [3:0] a);
        bit done;
        a    = '0;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (ack != 4'b0000) begin
                a    = ack;
                done = 1'b1;
            end
        end
    endtask

    // Waits for frame number > base_frames with at least nbits rising edges.
    task automatic wait_bits(input int base_frames, input int nbits, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (nframes > base_frames && nrise >= nbits) done = 1'b1;
        end
    endtask

    // directed sequence
    initial begin
        logic [3:0]  a;
        logic [15:0] dat [4];
        int          ord [5];
        int          base_acks;
        int          base_frames;

        dat[0] = 16'h8001; dat[1] = 16'h7FFE; dat[2] = 16'hA5C3; dat[3] = 16'h00FF;
        ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 3; ord[4] = 0;

        reset_n  = 1'b0;
        req      = '0;
        req_data = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_spi_clk", spi_clk, 1'b1);
        chk("rst_ncs", spi_ncs, 1'b1);
        chk("rst_mosi", spi_mosi, 1'b1);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 2'd0);
`ifdef SPI_REQ_ARBITER_READBACK_EN
        chk("rst_rd_data", rd_data, 16'h0000);
        chk("rst_rd_valid", rd_valid, 1'b0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // 1: single frame from requester 2
        req_data[2*16 +: 16] = 16'hA5C3;
        req = 4'b0100;
        wait_ack(400, a);
        chk("t1_ack", a, 4'b0100);
        chk("t1_grant_id", grant_id, 2'd2);
        chk("t1_busy_at_ack", busy, 1'b1);
        chk("t1_mosi_word", cap, 16'hA5C3);
        chk("t1_rise_count", nrise, 16);
        chk("t1_frames", nframes, 1);
        chk("t1_ncs_low_clks", lo_clks, 66);
        req = 4'b0000;
        @(negedge clk);
        chk("t1_ack_cleared", ack, 4'b0000);
        chk("t1_busy_after", busy, 1'b0);

        // 2: all four requesting, rotation from rr_ptr=3 after reset
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = dat[i];
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(400, a);
            chk("t2_ack", a, 32'(1 << ord[k]));
            chk("t2_grant_id", grant_id, 32'(ord[k]));
            chk("t2_mosi_word", cap, dat[ord[k]]);
            if (k > 0) chk("t2_ncs_gap_clks", hi_clks, 10);
        end
        req = 4'b0000;

        // 3: request withdrawn before arbitration is never served
        repeat (20) @(negedge clk);
        base_acks   = n_acks;
        base_frames = nframes;
        req = 4'b0010;
        repeat (2) @(negedge clk);
        req = 4'b0000;
        repeat (60) @(negedge clk);
        chk("t3_no_ack", n_acks, base_acks);
        chk("t3_no_frame", nframes, base_frames);
        chk("t3_ncs_high", spi_ncs, 1'b1);
        chk("t3_busy_low", busy, 1'b0);
        chk("t3_state_idle", dut.r_state, ST_IDLE);

        // 4: reset while bit 7 is on the wire, then re-service
        req_data[3*16 +: 16] = 16'h00FF;
        base_frames = nframes;
        req = 4'b1000;
        wait_bits(base_frames, 9, 400);
        chk("t4_at_bit7", nrise, 9);
        base_acks = n_acks;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_rst_ncs", spi_ncs, 1'b1);
        chk("t4_rst_spi_clk", spi_clk, 1'b1);
        chk("t4_rst_mosi", spi_mosi, 1'b1);
        chk("t4_rst_busy", busy, 1'b0);
        chk("t4_rst_ack", ack, 4'b0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("t4_no_ack_abort", n_acks, base_acks);
        wait_ack(400, a);
        chk("t4_reserve_ack", a, 4'b1000);
        chk("t4_reserve_word", cap, 16'h00FF);
        chk("t4_reserve_rises", nrise, 16);
        req = 4'b0000;

        // 5: req_data changes mid-frame, frame keeps the captured word
        req_data[2*16 +: 16] = 16'hA5C3;
        base_frames = nframes;
        req = 4'b0100;
        wait_bits(base_frames, 2, 400);
        req_data[2*16 +: 16] = 16'hFFFF;
        wait_ack(400, a);
        chk("t5_ack", a, 4'b0100);
        chk("t5_grant_id", grant_id, 2'd2);
        chk("t5_mosi_word", cap, 16'hA5C3);
        req = 4'b0000;

`ifdef SPI_REQ_ARBITER_READBACK_EN
        // 6: miso readback
        req_data[0 +: 16] = 16'h5555;
        req = 4'b0001;
        wait_ack(400, a);
        chk("t6_ack", a, 4'b0001);
        chk("t6_rd_valid", rd_valid, 1'b1);
        chk("t6_rd_data", rd_data, 16'h1234);
        chk("t6_mosi_word", cap, 16'h5555);
        req = 4'b0000;
        @(negedge clk);
        chk("t6_rd_valid_pulse", rd_valid, 1'b0);
`endif

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
